// File: rtl/issue_queue_sched_pkg.sv
// Shared constants and types for the decode-to-execute issue queue.
package issue_queue_sched_pkg;

    localparam int unsigned DS_TO_IS_BUS_WD = 212;
    localparam int unsigned IQ_DEPTH        = 4;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned NUM_REGS        = 32;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Register fields kept beside each queued payload for hazard checks.
    typedef struct packed {
        reg_idx_t rj;
        reg_idx_t rk;
        reg_idx_t dest;
        logic     gr_we;
    } iq_ctrl_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/iq_scoreboard.sv
// Pending-write scoreboard with same-cycle writeback bypass and a
// readiness check for the registers of the queue head.
module iq_scoreboard
    import issue_queue_sched_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     wb_valid,
    input  reg_idx_t wb_dest,
    input  logic     set_valid,
    input  reg_idx_t set_dest,
    input  iq_ctrl_t query,
    output logic     ready
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] eff_c;

    // A write issued this cycle wins over a writeback to the same register.
    always_comb begin
        eff_c = pending_q;
        if (wb_valid) begin
            eff_c = pending_q & ~reg_onehot(wb_dest);
        end
        pending_d = eff_c;
        if (set_valid && (set_dest != '0)) begin
            pending_d = pending_d | reg_onehot(set_dest);
        end
        pending_d[0] = 1'b0;
        ready = !eff_c[query.rj] && !eff_c[query.rk] &&
                !(query.gr_we && eff_c[query.dest]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/issue_queue_sched.sv
// In-order issue queue: buffers decoded instructions and releases the head
// to execute once its sources and destination are hazard-free.
module issue_queue_sched
    import issue_queue_sched_pkg::*;
#(
    parameter  int unsigned DEPTH  = IQ_DEPTH,
    parameter  int unsigned BUS_WD = DS_TO_IS_BUS_WD,
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ds_to_is_valid,
    input  logic [BUS_WD-1:0] ds_to_is_bus,
    input  logic [REG_W-1:0]  ds_rj,
    input  logic [REG_W-1:0]  ds_rk,
    input  logic [REG_W-1:0]  ds_dest,
    input  logic              ds_gr_we,
    output logic              IQ_allowin,
    input  logic              es_allowin,
    output logic              is_to_es_valid,
    output logic [BUS_WD-1:0] is_to_es_bus,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic              flush,
    output logic [PTR_W:0]    iq_count
);

    logic [BUS_WD-1:0] bus_mem_q  [DEPTH];
    iq_ctrl_t          ctrl_mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic     push_c;
    logic     pop_c;
    logic     not_empty_c;
    logic     sb_ready_c;
    logic     set_valid_c;
    iq_ctrl_t head_ctrl_c;
    iq_ctrl_t new_ctrl_c;

    iq_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_dest   (wb_dest),
        .set_valid (set_valid_c),
        .set_dest  (head_ctrl_c.dest),
        .query     (head_ctrl_c),
        .ready     (sb_ready_c)
    );

    // Handshakes; allowin looks only at registered occupancy.
    always_comb begin
        not_empty_c    = (count_q != '0);
        head_ctrl_c    = ctrl_mem_q[head_q];
        new_ctrl_c     = '{rj: ds_rj, rk: ds_rk, dest: ds_dest, gr_we: ds_gr_we};
        IQ_allowin     = (count_q < (PTR_W+1)'(DEPTH));
        is_to_es_valid = not_empty_c && sb_ready_c && !flush;
        is_to_es_bus   = not_empty_c ? bus_mem_q[head_q] : '0;
        iq_count       = count_q;
        pop_c          = is_to_es_valid && es_allowin;
        push_c         = ds_to_is_valid && IQ_allowin && !flush;
        set_valid_c    = pop_c && head_ctrl_c.gr_we;
    end

    // Pointer and occupancy update; flush empties the queue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_c) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push_c) begin
                tail_d = tail_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(push_c) - (PTR_W+1)'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed while occupied.
    always_ff @(posedge clk) begin
        if (push_c) begin
            bus_mem_q[tail_q]  <= ds_to_is_bus;
            ctrl_mem_q[tail_q] <= new_ctrl_c;
        end
    end

endmodule

// File: tb/tb_issue_queue_sched.sv
// Directed vector bench for issue_queue_sched: one table row per clock cycle.
module tb_issue_queue_sched;

    localparam int unsigned BUS_WD = 212;

    logic              clk = 1'b0;
    logic              reset;
    logic              ds_to_is_valid;
    logic [BUS_WD-1:0] ds_to_is_bus;
    logic [4:0]        ds_rj, ds_rk, ds_dest;
    logic              ds_gr_we;
    logic              IQ_allowin;
    logic              es_allowin;
    logic              is_to_es_valid;
    logic [BUS_WD-1:0] is_to_es_bus;
    logic              wb_valid;
    logic [4:0]        wb_dest;
    logic              flush;
    logic [2:0]        iq_count;

    int n_checks = 0;
    int n_fail   = 0;

    issue_queue_sched #(.DEPTH(4), .BUS_WD(BUS_WD)) dut (
        .clk            (clk),
        .reset          (reset),
        .ds_to_is_valid (ds_to_is_valid),
        .ds_to_is_bus   (ds_to_is_bus),
        .ds_rj          (ds_rj),
        .ds_rk          (ds_rk),
        .ds_dest        (ds_dest),
        .ds_gr_we       (ds_gr_we),
        .IQ_allowin     (IQ_allowin),
        .es_allowin     (es_allowin),
        .is_to_es_valid (is_to_es_valid),
        .is_to_es_bus   (is_to_es_bus),
        .wb_valid       (wb_valid),
        .wb_dest        (wb_dest),
        .flush          (flush),
        .iq_count       (iq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, fl, v;
        logic [4:0]  rj, rk, dst;
        logic        we;
        logic [15:0] tag;
        logic        es, wbv;
        logic [4:0]  wbd;
        logic        chk, e_allow, e_valid;
        logic [2:0]  e_cnt;
        logic [15:0] e_tag;
        logic        chk_p;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [BUS_WD-1:0] mk_bus(input logic [15:0] tag);
        return {tag, 180'b0, tag};
    endfunction

    function automatic vec_t mk(bit rst, bit fl, bit v, int rj, int rk, int dst, bit we,
                                int tag, bit es, bit wbv, int wbd, bit chk, bit ea,
                                bit ev, int ec, int etag, bit cp, int ep);
        vec_t r;
        r.rst = rst;  r.fl = fl;  r.v = v;
        r.rj = 5'(rj); r.rk = 5'(rk); r.dst = 5'(dst); r.we = we;
        r.tag = 16'(tag); r.es = es; r.wbv = wbv; r.wbd = 5'(wbd);
        r.chk = chk; r.e_allow = ea; r.e_valid = ev; r.e_cnt = 3'(ec);
        r.e_tag = 16'(etag); r.chk_p = cp; r.e_pend = 32'(ep);
        return r;
    endfunction

    task automatic check(input string nm, input int row, input logic [BUS_WD-1:0] act,
                         input logic [BUS_WD-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic rst_row();
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0));
    endtask

    initial begin
        // Independent stream: one issue per cycle, destinations left pending.
        rst_row();
        vecs.push_back(mk(0,0,1, 1, 2, 3,1,'hA1,1,0,0, 1,1,0,0,0,     1,0));
        vecs.push_back(mk(0,0,1, 4, 5, 6,1,'hB2,1,0,0, 1,1,1,1,'hA1,  0,0));
        vecs.push_back(mk(0,0,1, 7, 8, 9,1,'hC3,1,0,0, 1,1,1,1,'hB2,  0,0));
        vecs.push_back(mk(0,0,1,10,11,12,1,'hD4,1,0,0, 1,1,1,1,'hC3,  0,0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,0,0,   1,0,0, 1,1,1,1,'hD4,  0,0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,0,0,   1,0,0, 1,1,0,0,0,     1,'h1248));
        // RAW on r5: reader stalls two cycles, issues on the writeback cycle.
        rst_row();
        vecs.push_back(mk(0,0,1,0,0,5,1,'h21,1,0,0, 1,1,0,0,0,    0,0));
        vecs.push_back(mk(0,0,1,5,0,6,1,'h22,1,0,0, 1,1,1,1,'h21, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,0,1,'h22, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,0,1,'h22, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,1,5, 1,1,1,1,'h22, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,0,0,0,    1,'h40));
        // Full queue: fifth offer waits until the cycle after the first pop.
        rst_row();
        vecs.push_back(mk(0,0,1,0,0,0,0,'h31,0,0,0, 1,1,0,0,0,    0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h32,0,0,0, 1,1,1,1,'h31, 0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h33,0,0,0, 1,1,1,2,'h31, 0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h34,0,0,0, 1,1,1,3,'h31, 0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h35,0,0,0, 1,0,1,4,'h31, 0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h35,1,0,0, 1,0,1,4,'h31, 0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h35,0,0,0, 1,1,1,3,'h32, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   0,0,0, 1,0,1,4,'h32, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,0,1,4,'h32, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,1,3,'h33, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,1,2,'h34, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,1,1,'h35, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,0,0,0,    1,0));
        // Flush with a same-cycle offer; pending survives, writeback still honoured.
        rst_row();
        vecs.push_back(mk(0,0,1,0,0,7,1,'h41,1,0,0, 1,1,0,0,0,    0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h42,1,0,0, 1,1,1,1,'h41, 0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h43,0,0,0, 1,1,1,1,'h42, 0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h44,0,0,0, 1,1,1,2,'h42, 0,0));
        vecs.push_back(mk(0,1,1,0,0,0,0,'h45,1,0,0, 1,1,0,3,'h42, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,0,0,0,    1,'h80));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,   1,1,7, 1,1,0,0,0,    0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,0,0,0,    1,0));
        // WAW on r9 resolved by a coincident writeback; the new write stays pending.
        rst_row();
        vecs.push_back(mk(0,0,1,0,0,9,1,'h51,1,0,0, 1,1,0,0,0,    0,0));
        vecs.push_back(mk(0,0,1,0,0,9,1,'h52,1,0,0, 1,1,1,1,'h51, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,0,1,'h52, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,1,9, 1,1,1,1,'h52, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,0,0,0,    1,'h200));
        // Reset mid-operation, with flush and an offer in the same cycle.
        rst_row();
        vecs.push_back(mk(0,0,1,0,0,3,1,'h61,1,0,0, 1,1,0,0,0,    0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h62,1,0,0, 1,1,1,1,'h61, 0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,'h63,0,0,0, 1,1,1,1,'h62, 0,0));
        vecs.push_back(mk(1,1,1,0,0,0,0,'h64,1,0,0, 1,1,0,2,'h62, 1,'h8));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0, 1,1,0,0,0,    1,0));

        reset = 1'b1; flush = 1'b0; ds_to_is_valid = 1'b0; ds_to_is_bus = '0;
        ds_rj = '0; ds_rk = '0; ds_dest = '0; ds_gr_we = 1'b0;
        es_allowin = 1'b0; wb_valid = 1'b0; wb_dest = '0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            reset          = vecs[i].rst;
            flush          = vecs[i].fl;
            ds_to_is_valid = vecs[i].v;
            ds_rj          = vecs[i].rj;
            ds_rk          = vecs[i].rk;
            ds_dest        = vecs[i].dst;
            ds_gr_we       = vecs[i].we;
            ds_to_is_bus   = mk_bus(vecs[i].tag);
            es_allowin     = vecs[i].es;
            wb_valid       = vecs[i].wbv;
            wb_dest        = vecs[i].wbd;
            @(negedge clk);
            if (vecs[i].chk) begin
                check("allowin", i, BUS_WD'(IQ_allowin), BUS_WD'(vecs[i].e_allow));
                check("valid",   i, BUS_WD'(is_to_es_valid), BUS_WD'(vecs[i].e_valid));
                check("count",   i, BUS_WD'(iq_count), BUS_WD'(vecs[i].e_cnt));
                check("bus",     i, is_to_es_bus, mk_bus(vecs[i].e_tag));
            end
            if (vecs[i].chk_p) begin
                check("pending", i, BUS_WD'(dut.u_sb.pending_q), BUS_WD'(vecs[i].e_pend));
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue_sched.md
# issue_queue_sched

In-order issue queue and scoreboard scheduler between the decode stage and the execute stage of the 6-stage pipeline. It buffers decoded instructions and tracks pending register writes. It releases the oldest entry to execute only when its source registers and destination register are hazard-free. It drives the decode stage's `IQ_allowin` and absorbs branch-mispredict flushes.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `BUS_WD`, 212: width of the decoded-instruction payload, carried opaquely.
- `PTR_W`, log2(DEPTH): pointer width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `ds_to_is_valid`  in  1  decode offers an instruction.
- `ds_to_is_bus`  in  BUS_WD  decoded payload.
- `ds_rj`  in  5  source register 1; 0 means unused.
- `ds_rk`  in  5  source register 2; 0 means unused.
- `ds_dest`  in  5  destination register.
- `ds_gr_we`  in  1  instruction writes `ds_dest`.
- `IQ_allowin`  out  1  queue accepts this cycle.
- `es_allowin`  in  1  execute stage accepts this cycle.
- `is_to_es_valid`  out  1  head entry is issuing.
- `is_to_es_bus`  out  BUS_WD  head payload.
- `wb_valid`  in  1  writeback retires a register write.
- `wb_dest`  in  5  register being written back.
- `flush`  in  1  mispredict or exception; discard queued entries.
- `iq_count`  out  PTR_W+1  occupancy.

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry holds {bus, rj, rk, dest, gr_we}. There is a head pointer, a tail pointer and a count.
- Enqueue happens when `ds_to_is_valid && IQ_allowin && !flush`. The entry is written at tail, and tail wraps modulo DEPTH.
- `IQ_allowin` = (count < DEPTH). It depends on registered state only, so a same-cycle pop does not free a slot for that cycle's push.
- The scoreboard is a 32-bit `pending` vector. Bit 0 is hard-wired to 0.
- An effective-pending view is used for the readiness check: eff = pending & ~(wb_valid ? onehot(wb_dest) : 0). This gives same-cycle writeback bypass.
- Head is ready when count>0 and all of the following hold:
  - !eff[rj] and !eff[rk];
  - if gr_we, !eff[dest]. This is a WAW stall, needed because writebacks can return out of order (load vs ALU).
- `is_to_es_valid` = head ready && !flush.
- Pop happens when `is_to_es_valid && es_allowin`. Head advances.
- Scoreboard next state:
  - A writeback clears `pending[wb_dest]`.
  - A pop with gr_we and dest≠0 sets `pending[dest]`.
  - If both hit the same register, set wins. The WAW check makes this case reachable only when wb and issue coincide on a freed register.
- Flush:
  - Next cycle, count=0 and head=tail=0. Any same-cycle enqueue or issue is suppressed.
  - `pending` is NOT cleared, because older instructions already issued still write back.
  - `wb_valid` is still honoured during flush.
- Simultaneous push and pop leave count unchanged.
- Push at full cannot occur, because `IQ_allowin` is 0.
- Pop at empty cannot occur, because valid is 0.

## Timing
- Reset values:
  - count=0, head=0, tail=0, pending=0.
  - `IQ_allowin`=1, `is_to_es_valid`=0, `is_to_es_bus`=0, `iq_count`=0.
- Reset has priority over flush, and flush has priority over push and pop.
- Latency: an entry enqueued at cycle N is visible at head, and issues, no earlier than N+1. There is no fall-through path.
- Back-to-back dependent instructions: the consumer stalls until the cycle in which `wb_valid` with a matching `wb_dest` is asserted. It issues in that same cycle via the bypass.
- `is_to_es_bus` is combinational from the head entry. It is zero when count=0.
- Throughput is 1 issue per cycle when there are no hazards.

## Structure
- Shared header `myCPU.vh` holds `DS_TO_IS_BUS_WD` (default for BUS_WD) and the `IQ_DEPTH` constant.
- One natural sub-module, `iq_scoreboard`. It holds the 32-bit pending vector, the bypass view, the set/clear logic and a `ready` output for three queried registers.
- The FIFO storage and pointers stay in the top module.

## Test plan
1. Independent stream:
   - Stimulus: enqueue 4 instructions with rj/rk/dest = {1,2,3}, {4,5,6}, {7,8,9}, {10,11,12}, gr_we=1, `es_allowin`=1.
   - Required response: one issue per cycle starting the cycle after the first enqueue; pending bits 3, 6, 9 and 12 set.
2. RAW stall plus bypass:
   - Stimulus: issue a write to r5; the next instruction reads r5; `wb_valid`/`wb_dest`=5 is asserted 3 cycles later.
   - Required response: the reader holds `is_to_es_valid`=0 for 2 cycles and issues in the writeback cycle.
3. Full queue:
   - Stimulus: `es_allowin`=0 and 5 offers.
   - Required response: `IQ_allowin` drops after the 4th accept; `iq_count`=4; the 5th is not accepted until the cycle after the first pop.
4. Flush:
   - Stimulus: 3 entries queued, r7 pending; assert flush together with `ds_to_is_valid`.
   - Required response: next cycle `iq_count`=0, no issue, the offered instruction is dropped, `pending[7]` is still 1.
5. WAW and simultaneous set/clear:
   - Stimulus: r9 pending; an instruction writing r9 is at head; `wb_dest`=9 arrives.
   - Required response: it issues that cycle and `pending[9]` remains 1.
6. Reset mid-operation:
   - Stimulus: assert reset with 2 entries queued and pending≠0.
   - Required response: all outputs go to reset values next cycle and `pending`=0.
